// File: rtl/umi_port_arbiter.sv
// Round-robin arbiter sharing one UMI stream among N requesters, message-atomic via EOM.
// Latency: zero cycles; the output is a combinational mux of the granted requester.
// Backpressure: umi_out_ready is forwarded to the granted requester only; a stalled offer holds the grant.
module umi_port_arbiter #(
    parameter int N      = 4,
    parameter int DW     = 256,
    parameter int AW     = 64,
    parameter int CW     = 32,
    parameter int EOMBIT = 22
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [CW-1:0]   umi_out_cmd,
    output logic [AW-1:0]   umi_out_dstaddr,
    output logic [AW-1:0]   umi_out_srcaddr,
    output logic [DW-1:0]   umi_out_data,
    input  logic            umi_out_ready,
    output logic [N-1:0]    grant,
    output logic            busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // IDLE: free arbitration; HOLD: first beat offered but stalled; LOCK: inside a multi-beat message
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_LOCK
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   sel_q, sel_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;
    logic            xfer;
    logic            eom;

    // Increment an index with wrap from N-1 back to 0
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
        return (x == PW'(N - 1)) ? '0 : x + PW'(1);
    endfunction

    // First valid requester scanning ptr, ptr+1, ... modulo N
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N; k++) begin
            int            j;
            logic [PW-1:0] cand;
            j = int'(ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            cand = PW'(j);
            if (!win_found && umi_in_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant source: live winner in IDLE, registered owner otherwise; reset forces no grant and index 0
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (nreset) begin
            if (state_q == ST_IDLE) begin
                gnt_vld = win_found;
                gnt_idx = win_idx;
            end else begin
                gnt_vld = 1'b1;
                gnt_idx = sel_q;
            end
        end
    end

    // Output mux and handshake; payload falls back to requester 0 when nothing is granted
    always_comb begin
        grant           = gnt_vld ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
        umi_in_ready    = grant & {N{umi_out_ready}};
        umi_out_valid   = |(grant & umi_in_valid);
        umi_out_cmd     = umi_in_cmd[gnt_idx*CW +: CW];
        umi_out_dstaddr = umi_in_dstaddr[gnt_idx*AW +: AW];
        umi_out_srcaddr = umi_in_srcaddr[gnt_idx*AW +: AW];
        umi_out_data    = umi_in_data[gnt_idx*DW +: DW];
        xfer            = umi_out_valid & umi_out_ready;
        eom             = umi_out_cmd[EOMBIT];
        busy            = (state_q != ST_IDLE);
    end

    // Next-state: lock on non-final beats, hold on stalled offers, rotate ptr only on completed messages
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    if (xfer) begin
                        if (eom) begin
                            ptr_d = wrap_inc(win_idx);
                        end else begin
                            state_d = ST_LOCK;
                            sel_d   = win_idx;
                        end
                    end else begin
                        state_d = ST_HOLD;
                        sel_d   = win_idx;
                    end
                end
            end
            ST_HOLD: begin
                if (!umi_in_valid[sel_q]) begin
                    // Requester withdrew a stalled offer: release without moving priority
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    if (eom) begin
                        state_d = ST_IDLE;
                        ptr_d   = wrap_inc(sel_q);
                    end else begin
                        state_d = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                if (xfer && eom) begin
                    state_d = ST_IDLE;
                    ptr_d   = wrap_inc(sel_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, priority pointer and owner registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_umi_port_arbiter.sv
// Bench for umi_port_arbiter: directed scenarios plus random traffic against an owner/pointer model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// The model tracks who owns the port and whether a message is in progress.
module tb_umi_port_arbiter;

    localparam int N      = 4;
    localparam int DW     = 64;
    localparam int AW     = 64;
    localparam int CW     = 32;
    localparam int EOMBIT = 22;

    logic            clk;
    logic            nreset;
    logic [N-1:0]    umi_in_valid;
    logic [N*CW-1:0] umi_in_cmd;
    logic [N*AW-1:0] umi_in_dstaddr;
    logic [N*AW-1:0] umi_in_srcaddr;
    logic [N*DW-1:0] umi_in_data;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [CW-1:0]   umi_out_cmd;
    logic [AW-1:0]   umi_out_dstaddr;
    logic [AW-1:0]   umi_out_srcaddr;
    logic [DW-1:0]   umi_out_data;
    logic            umi_out_ready;
    logic [N-1:0]    grant;
    logic            busy;

    logic [CW-1:0] cmd_a [N];
    logic [AW-1:0] dst_a [N];
    logic [AW-1:0] src_a [N];
    logic [DW-1:0] dat_a [N];

    int checks;
    int errors;

    // Model: owner = requester holding the port (-1 when free), in_msg = a non-final beat was accepted
    int m_owner;
    bit m_in_msg;
    int m_ptr;

    umi_port_arbiter #(.N(N), .DW(DW), .AW(AW), .CW(CW), .EOMBIT(EOMBIT)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready),
        .grant           (grant),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            umi_in_cmd[i*CW +: CW]     = cmd_a[i];
            umi_in_dstaddr[i*AW +: AW] = dst_a[i];
            umi_in_srcaddr[i*AW +: AW] = src_a[i];
            umi_in_data[i*DW +: DW]    = dat_a[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input bit eom_bit);
        logic [CW-1:0] c;
        c = CW'($urandom);
        c[EOMBIT] = eom_bit;
        cmd_a[i] = c;
        dst_a[i] = {$urandom, $urandom};
        src_a[i] = {$urandom, $urandom};
        dat_a[i] = {$urandom, $urandom};
    endtask

    function automatic int model_pick();
        if (m_owner >= 0) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (umi_in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_in_msg = 1'b0;
        m_ptr    = 0;
    endtask

    // One clock: check outputs against the model at the falling edge, advance the model at the rising edge.
    // want >= 0 additionally pins the grant to that requester, -1 pins it to none, -2 skips that check.
    task automatic do_cycle(input string tag, input int want);
        int            g;
        logic [N-1:0]  eg;
        logic [N-1:0]  er;
        logic          ev;
        bit            fin;
        @(negedge clk);
        g  = model_pick();
        eg = (g >= 0) ? N'(1) << g : '0;
        ev = (g >= 0) ? umi_in_valid[g] : 1'b0;
        er = umi_out_ready ? eg : '0;
        chk({tag, ":grant"}, 64'(grant), 64'(eg));
        chk({tag, ":in_ready"}, 64'(umi_in_ready), 64'(er));
        chk({tag, ":out_valid"}, 64'(umi_out_valid), 64'(ev));
        chk({tag, ":busy"}, 64'(busy), 64'(m_owner >= 0));
        if (g >= 0) begin
            chk({tag, ":cmd"}, 64'(umi_out_cmd), 64'(cmd_a[g]));
            chk({tag, ":dst"}, 64'(umi_out_dstaddr), 64'(dst_a[g]));
            chk({tag, ":src"}, 64'(umi_out_srcaddr), 64'(src_a[g]));
            chk({tag, ":data"}, 64'(umi_out_data), 64'(dat_a[g]));
        end
        if (want != -2) begin
            chk({tag, ":plan"}, 64'(grant), (want < 0) ? 64'd0 : 64'd1 << want);
        end
        @(posedge clk);
        if (g >= 0) begin
            fin = cmd_a[g][EOMBIT];
            if (ev && umi_out_ready) begin
                if (fin) begin
                    m_owner  = -1;
                    m_in_msg = 1'b0;
                    m_ptr    = (g + 1) % N;
                end else begin
                    m_owner  = g;
                    m_in_msg = 1'b1;
                end
            end else if (m_owner < 0) begin
                m_owner  = g;
                m_in_msg = 1'b0;
            end else if (!m_in_msg && !ev) begin
                m_owner = -1;
            end
        end
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        for (int i = 0; i < N; i++) load(i, 1'b1);
        umi_in_valid  = 4'b1010;
        umi_out_ready = 1'b1;
        nreset        = 1'b0;

        // Reset: requests present but nothing granted, payload from requester 0
        #3;
        chk("rst:grant", 64'(grant), 64'd0);
        chk("rst:in_ready", 64'(umi_in_ready), 64'd0);
        chk("rst:out_valid", 64'(umi_out_valid), 64'd0);
        chk("rst:busy", 64'(busy), 64'd0);
        chk("rst:cmd", 64'(umi_out_cmd), 64'(cmd_a[0]));
        chk("rst:data", 64'(umi_out_data), 64'(dat_a[0]));
        @(posedge clk);
        @(posedge clk);
        #1;
        nreset       = 1'b1;
        umi_in_valid = '0;

        // Fair rotation: all valid, single-beat messages
        umi_in_valid = 4'b1111;
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < N; i++) load(i, 1'b1);
            do_cycle("rotate", s % N);
        end

        // Move ptr to 1 with a lone req0 beat
        umi_in_valid = 4'b0001;
        load(0, 1'b1);
        do_cycle("prep", 0);

        // Atomic 3-beat message from req1 while req0 and req2 compete
        umi_in_valid = 4'b0111;
        load(0, 1'b1);
        load(2, 1'b1);
        for (int b = 0; b < 3; b++) begin
            load(1, b == 2);
            do_cycle("atomic", 1);
        end
        do_cycle("atomic_next", 2);

        // Stall stability: req3 offered with ready low, req0 joins later
        umi_in_valid  = 4'b1000;
        umi_out_ready = 1'b0;
        load(3, 1'b1);
        load(0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) umi_in_valid = 4'b1001;
            do_cycle("stall", 3);
        end
        umi_out_ready = 1'b1;
        do_cycle("stall_go", 3);
        do_cycle("stall_next", 0);

        // Lock with gaps: req2 keeps the port while silent
        umi_in_valid = 4'b0101;
        load(0, 1'b1);
        load(2, 1'b0);
        do_cycle("gap_first", 2);
        umi_in_valid = 4'b0001;
        for (int c = 0; c < 4; c++) do_cycle("gap", 2);
        umi_in_valid = 4'b0101;
        load(2, 1'b1);
        do_cycle("gap_last", 2);
        do_cycle("gap_next", 0);

        // Reset in the middle of req1's message
        umi_in_valid = 4'b0010;
        load(1, 1'b0);
        do_cycle("mid_a", 1);
        do_cycle("mid_b", 1);
        #2;
        nreset = 1'b0;
        #1;
        chk("arst:grant", 64'(grant), 64'd0);
        chk("arst:in_ready", 64'(umi_in_ready), 64'd0);
        chk("arst:out_valid", 64'(umi_out_valid), 64'd0);
        chk("arst:busy", 64'(busy), 64'd0);
        model_reset();
        umi_in_valid = 4'b1111;
        for (int i = 0; i < N; i++) load(i, 1'b1);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        do_cycle("after_rst", 0);

        // Idle then a lone req3 beat, zero latency, ptr wraps to 0
        umi_in_valid = '0;
        for (int c = 0; c < 10; c++) do_cycle("idle", -1);
        umi_in_valid = 4'b1000;
        load(3, 1'b1);
        do_cycle("sparse", 3);
        umi_in_valid = 4'b1111;
        do_cycle("wrap", 0);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            umi_in_valid  = N'($urandom);
            umi_out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) load(i, $urandom_range(0, 2) != 0);
            do_cycle("rand", -2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/umi_port_arbiter.md
Name: umi_port_arbiter

Overview:
Round-robin arbiter that shares one UMI stream among N requesters. Typical use is several UMI request sources feeding a single umi_fifo or device port.
Multi-cycle transactions are kept atomic: the grant locks to one requester until a beat with the EOM bit set is accepted.
The output is combinational from the granted input, so the block adds zero cycles of latency. A registered state machine keeps the grant stable while the output is stalled.

Parameters:
N, 4, number of requesters (2..16)
DW, 256, UMI data width
AW, 64, UMI address width
CW, 32, UMI command width
EOMBIT, 22, bit index of the end-of-message flag within cmd

Ports:
clk  input  1  single clock for all logic
nreset  input  1  asynchronous active-low reset
umi_in_valid  input  N  per-requester valid
umi_in_cmd  input  N*CW  packed commands; requester i uses slice [i*CW +: CW]
umi_in_dstaddr  input  N*AW  packed destination addresses
umi_in_srcaddr  input  N*AW  packed source addresses
umi_in_data  input  N*DW  packed data
umi_in_ready  output  N  per-requester ready
umi_out_valid  output  1  shared output valid
umi_out_cmd  output  CW  command of the granted requester
umi_out_dstaddr  output  AW  destination address of the granted requester
umi_out_srcaddr  output  AW  source address of the granted requester
umi_out_data  output  DW  data of the granted requester
umi_out_ready  input  1  downstream ready
grant  output  N  one-hot current grant, or 0 when there is none
busy  output  1  high in the HOLD or LOCK state

Behaviour:
- Reset (nreset low, asynchronous):
  - State goes to IDLE and the priority pointer ptr goes to 0.
  - grant=0, umi_in_ready=0, umi_out_valid=0, busy=0.
  - umi_out_* payload outputs are don't-care but must be driven from requester 0's slices (no X).
- Reset mid-transaction: any lock is dropped. After release, arbitration restarts from ptr=0.
- Handshake: a beat transfers when umi_out_valid & umi_out_ready.
  - umi_in_ready[i] = grant[i] & umi_out_ready.
  - umi_out_valid = |(grant & umi_in_valid).
  - umi_out_* carries the slices of the granted index.
- States: IDLE, HOLD, LOCK. Registers: ptr (clog2(N) bits) and sel (granted index).
- IDLE:
  - grant is combinational: the first valid requester scanning ptr, ptr+1, ... modulo N.
  - Transfer with cmd[EOMBIT]=1: stay in IDLE, ptr <= winner+1 modulo N.
  - Transfer with cmd[EOMBIT]=0: go to LOCK, sel <= winner.
  - Offered but not accepted (valid & !ready): go to HOLD, sel <= winner.
  - No valid requester: grant=0, nothing changes.
- HOLD:
  - grant = onehot(sel) regardless of other requests. The payload must not change while stalled.
  - Transfer with EOM=1: go to IDLE, ptr <= sel+1.
  - Transfer with EOM=0: go to LOCK.
  - umi_in_valid[sel] dropped (protocol violation): go to IDLE next cycle. ptr is unchanged.
- LOCK:
  - grant = onehot(sel). Other requesters get ready=0 even if sel has no valid beat.
  - Transfer with EOM=1: go to IDLE, ptr <= sel+1.
  - Gaps in the granted requester's valid do not release the lock.
- Fairness:
  - A requester that completes a message moves to lowest priority.
  - Any continuously requesting input is served within N-1 messages.
- Wrap-around: ptr and winner+1 wrap from N-1 to 0.
- Simultaneous events:
  - Requests arriving in the same cycle as an accepted EOM beat are arbitrated next cycle using the updated ptr.
  - There is no same-cycle regrant.
- busy = (state != IDLE).
- The block holds no buffering. Throughput is one beat per cycle when umi_out_ready is held high.

Test Plan:
1. Fair rotation: N=4, all valid held high, every beat EOM=1, umi_out_ready=1 → grant sequence 0,1,2,3,0,1 on consecutive cycles; one beat per cycle.
2. Atomic message: req1 sends a 3-beat message (EOM 0,0,1) while req0 and req2 are valid → three req1 beats back-to-back, then req2 is granted. req0's ready stays 0 throughout.
3. Stall stability: only req3 is valid with umi_out_ready=0 for 5 cycles; req0 raises valid in cycle 2 → grant stays 0b1000 and the payload is unchanged. After ready rises, req3 transfers first and req0 follows next cycle.
4. Lock with gaps: req2 sends EOM=0 then drops valid for 4 cycles while req0 is valid → grant stays 0b0100 and umi_out_valid=0. When req2 returns with EOM=1 it is accepted, then req0 is granted.
5. Reset mid-LOCK: assert nreset low during req1's message → grant, umi_in_ready and umi_out_valid go to 0 immediately. After release with all valid, the first grant is req0.
6. Idle/sparse: no valid for 10 cycles, then a single req3 beat → grant=0 during the idle cycles. req3 transfers in the same cycle it asserts valid (zero latency), then ptr=0.
